// File: rtl/uart_rx_port.sv
// rtl/uart_rx_port.sv - 8N1 UART receiver presenting a held byte plus status to a CPU register word.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits (8E1 framing).
module uart_rx_port #(
  parameter int CLKS_PER_BIT = 104,
  parameter int WIDTH_REG    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 ack,
  output logic [WIDTH_REG-1:0] port_in
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_err_q, par_err_d;
  logic            rx_meta_q, rx_s_q;
  logic            ack_q, ack_prev_q;
  logic            ack_rise;
  logic            frame_done, frame_ferr, frame_perr;
  logic [7:0]      data_q;
  logic            valid_q, ovr_q, ferr_q, perr_q;

  assign ack_rise = ack_q & ~ack_prev_q;

`ifdef UART_RX_PARITY_EN
  assign frame_perr = par_err_q;
`else
  assign frame_perr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!rx_s_q) state_d = S_START;
      S_START: if (cnt_q == HALF_CNT) state_d = rx_s_q ? S_IDLE : S_DATA;
      S_DATA: begin
        if (cnt_q == LAST_CNT && bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (cnt_q == LAST_CNT) state_d = S_STOP;
`endif
      S_STOP:  if (cnt_q == LAST_CNT) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter restarts at every decision point, so it never runs past one bit period.
  always_comb begin
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    frame_done = 1'b0;
    frame_ferr = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_d     = '0;
        par_err_d = 1'b0;
      end
      S_START: if (cnt_q == HALF_CNT) cnt_d = '0;
      S_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          bit_d   = bit_q + 3'd1;
          shift_d = {rx_s_q, shift_q[7:1]};
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          par_err_d = rx_s_q ^ (^shift_q);
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d      = '0;
          frame_done = 1'b1;
          frame_ferr = ~rx_s_q;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      ack_q      <= 1'b0;
      ack_prev_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      ack_q      <= ack;
      ack_prev_q <= ack_q;
      if (frame_done && (!valid_q || ack_rise)) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
        ovr_q   <= 1'b0;
        ferr_q  <= frame_ferr;
        perr_q  <= frame_perr;
      end else if (frame_done) begin
        ovr_q <= 1'b1;
      end else if (ack_rise && valid_q) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
        ferr_q  <= 1'b0;
        perr_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    port_in        = '0;
    port_in[11:0]  = {perr_q, ferr_q, ovr_q, valid_q, data_q};
  end

endmodule

// File: doc/uart_rx_port.md
UART_RX_PORT -- requirements
Module: uart_rx_port

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, clock cycles per serial bit (12 MHz / 115200); legal range 4..65535.
REQ-002 Parameter WIDTH_REG, default 32, width of port_in; minimum 12.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx  input  1  asynchronous serial line, idle high, 8N1 framing (8E1 with parity option).
REQ-006 ack  input  1  CPU acknowledge; the top level drives it from a port_out bit; a rising edge consumes the held byte.
REQ-007 port_in  output  WIDTH_REG  status/data word for the CPU: [7:0] data, [8] valid, [9] overrun, [10] framing error, [11] parity error, upper bits 0.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; all FSM decisions use the second flop (rx_s).
REQ-011 ack SHALL be registered once; ack_rise = ack_reg & ~ack_prev, evaluated each cycle.
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY (option only), STOP.
REQ-013 IDLE -> START on the first cycle rx_s = 0; the bit counter clears and the cycle counter loads 0.
REQ-014 START: at cycle counter = CLKS_PER_BIT/2 (floor), rx_s = 1 -> IDLE (glitch, nothing reported); rx_s = 0 -> DATA with the cycle counter restarted.
REQ-015 DATA: samples rx_s every CLKS_PER_BIT cycles; 8 bits, LSB first, shifted into a receive shift register; after bit 7 -> PARITY (option) or STOP.
REQ-016 Bit k (0..7) SHALL be sampled CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT cycles after the IDLE->START transition.
REQ-017 STOP: samples one bit period after the last data/parity sample; frame completes on that cycle; rx_s = 0 marks a framing error; -> IDLE next cycle with no wait for line idle.
REQ-018 On frame completion with valid = 0: data <= shift register, valid <= 1, ferr/perr <= frame status; port_in updates on the following cycle (1-cycle latency from the stop sample).
REQ-019 On frame completion with valid = 1 and no ack_rise that cycle: the held data is unchanged, overrun <= 1, and the new byte is discarded.
REQ-020 ack_rise with no completion that cycle: valid, overrun, ferr and perr clear to 0; data holds its last value.
REQ-021 ack_rise on the same cycle as completion: the new byte loads as in REQ-018, overrun clears, and valid stays 1.
REQ-022 ack_rise while valid = 0 has no effect.
REQ-023 The cycle counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL never wrap inside a bit period.
REQ-024 port_in SHALL be driven from registers only, with no combinational path from rx or ack.
REQ-025 A continuous low line (break) SHALL produce one frame with data 0x00 and ferr = 1, then restart from IDLE while rx stays low.

Reset
REQ-030 While reset = 1, the FSM enters IDLE, all counters go to 0, and the synchronizer flops and ack_prev go to 1 and 0 respectively.
REQ-031 Reset SHALL force port_in to all zeros on the next clock edge.
REQ-032 Reset mid-frame SHALL abandon the frame; after reset release the block waits for a fresh falling edge and does not resume the partial byte.

Configuration
REQ-040 Macro UART_RX_PARITY_EN: when defined, PARITY state samples an even-parity bit after bit 7; a mismatch sets perr (port_in[11]) with the byte still delivered; STOP follows one bit later.
REQ-041 UART_RX_PARITY_EN undefined: no PARITY state, frame is 10 bits, and port_in[11] is constant 0.

Verification (CLKS_PER_BIT = 16)
REQ-050 Send 0xA5 with a good stop bit -> 1 cycle after the stop sample port_in = 0x1A5; pulse ack -> port_in = 0x0A5.
REQ-051 Drive rx low for 5 cycles and then high -> no frame, port_in stays 0x000, and the FSM is back in IDLE by cycle 9.
REQ-052 Send 0x3C, no ack, then send 0x7E -> port_in = 0x33C (overrun, old data kept); ack -> 0x03C.
REQ-053 Send 0x55 with stop bit = 0 -> port_in = 0x555 (valid and framing error).
REQ-054 Assert reset 40 cycles into a frame, release, then send 0x81 -> port_in reads 0x000 during reset and 0x181 after the frame, with no residue from the first frame.
REQ-055 With UART_RX_PARITY_EN defined, send 0x01 with parity bit 0 -> port_in = 0x901 (valid and parity error); with parity bit 1 -> 0x101.
